// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop serializer.
// Back-to-back frames go out with no idle gap while the FIFO holds data.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned ADDR_W       = 3
) (
  input  logic              i_Clock,
  input  logic              i_Rst_L,
  input  logic              i_DV,
  input  logic [7:0]        i_TX_Byte,
  output logic              o_Ready,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_TX_Serial,
  output logic              o_TX_Active,
  output logic              o_TX_Done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0]    FULL     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  clk_cnt, clk_cnt_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic [7:0]        shift, shift_d;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0]     count_d;
  logic              push, pop;
  logic              serial_d, active_d, done_d;

  // Ready comes from the registered count, so a full FIFO rejects even on a pop cycle
  assign push = i_DV && o_Ready;

  // Next-state, pop decision and registered-output values
  always_comb begin
    state_d   = state;
    clk_cnt_d = clk_cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    done_d    = 1'b0;
    serial_d  = 1'b1;
    active_d  = 1'b0;

    case (state)
      IDLE: begin
        if (o_Count != '0) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr];
          clk_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_d = '0;
          if (o_Count != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
          // Done is registered, so raise it one clock ahead of the last stop clock
          done_d    = (clk_cnt == CNT_PRE);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   begin serial_d = 1'b0;               active_d = 1'b1; end
      DATA:    begin serial_d = shift_d[bit_idx_d]; active_d = 1'b1; end
      STOP:    begin serial_d = 1'b1;               active_d = 1'b1; end
      default: begin serial_d = 1'b1;               active_d = 1'b0; end
    endcase

    count_d = o_Count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      o_Count     <= '0;
      o_Ready     <= 1'b1;
      o_Overflow  <= 1'b0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      state       <= state_d;
      clk_cnt     <= clk_cnt_d;
      bit_idx     <= bit_idx_d;
      shift       <= shift_d;
      o_Count     <= count_d;
      o_Ready     <= (count_d != FULL);
      o_TX_Serial <= serial_d;
      o_TX_Active <= active_d;
      o_TX_Done   <= done_d;
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (i_DV && !o_Ready) o_Overflow <= 1'b1;
    end
  end

  // Storage has no reset; pointers and count define which entries are valid
  always_ff @(posedge i_Clock) begin
    if (i_Rst_L && push) mem[wr_ptr] <= i_TX_Byte;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: single frame, bursts, overflow, loopback decode, reset abort.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CPB   = 217;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst_l;
  logic       dv;
  logic [7:0] tx_byte;
  logic       ready;
  logic [3:0] count;
  logic       overflow;
  logic       serial;
  logic       active;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] rx_q[$];
  int         done_q[$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .ADDR_W(3)) dut (
    .i_Clock    (clk),
    .i_Rst_L    (rst_l),
    .i_DV       (dv),
    .i_TX_Byte  (tx_byte),
    .o_Ready    (ready),
    .o_Count    (count),
    .o_Overflow (overflow),
    .o_TX_Serial(serial),
    .o_TX_Active(active),
    .o_TX_Done  (done)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle stamp of every Done pulse
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (done === 1'b1) done_q.push_back(cyc);
  end

  // Independent UART receiver: detects start, samples mid-bit, keeps bytes with a valid stop
  initial forever begin
    logic [7:0] b;
    @(posedge clk);
    #1;
    if (serial === 1'b0) begin
      repeat (CPB / 2) tick();
      if (serial === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) tick();
          b[i] = serial;
        end
        repeat (CPB) tick();
        if (serial === 1'b1) rx_q.push_back(b);
      end
    end
  end

  task automatic do_reset();
    rst_l = 1'b0;
    dv    = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
    tick();
    rx_q.delete();
    done_q.delete();
  endtask

  task automatic wait_dones(input int n, input int budget, output bit ok);
    int b;
    b = budget;
    while (done_q.size() < n && b > 0) begin
      tick();
      b--;
    end
    ok = (done_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_l   = 1'b0;
    dv      = 1'b1;
    tx_byte = 8'hA5;
    repeat (3) tick();
    checks++; if (serial !== 1'b1)   begin failures++; $display("FAIL rst_serial got=%b exp=1", serial); end
    checks++; if (active !== 1'b0)   begin failures++; $display("FAIL rst_active got=%b exp=0", active); end
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (ready !== 1'b1)    begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
    checks++; if (count !== 4'd0)    begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    dv = 1'b0;
    rst_l = 1'b1;
    repeat (3) tick();
    checks++; if (active !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL rst_release got=%b/%0d exp=0/0", active, count); end
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic       exp_bit;
    int         dn;
    int         dn_at;
    do_reset();
    b = 8'h37;
    dn = 0;
    dn_at = -1;
    dv = 1'b1;
    tx_byte = b;
    tick();
    dv = 1'b0;
    checks++; if (count !== 4'd1)  begin failures++; $display("FAIL single_count_push got=%0d exp=1", count); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL single_active_push got=%b exp=0", active); end
    tick();
    checks++; if (count !== 4'd0)  begin failures++; $display("FAIL single_count_pop got=%0d exp=0", count); end
    checks++; if (serial !== 1'b0) begin failures++; $display("FAIL single_start_low got=%b exp=0", serial); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL single_active got=%b exp=1", active); end
    for (int c = 0; c < FRAME + 5; c++) begin
      if (c < FRAME && (c % CPB) == CPB / 2) begin
        if (c / CPB == 0)      exp_bit = 1'b0;
        else if (c / CPB == 9) exp_bit = 1'b1;
        else                   exp_bit = b[c / CPB - 1];
        checks++;
        if (serial !== exp_bit) begin failures++; $display("FAIL single_bit%0d got=%b exp=%b", c / CPB, serial, exp_bit); end
      end
      if (done === 1'b1) begin dn++; dn_at = c; end
      tick();
    end
    checks++; if (dn !== 1)           begin failures++; $display("FAIL single_done_count got=%0d exp=1", dn); end
    checks++; if (dn_at !== FRAME - 1) begin failures++; $display("FAIL single_done_cycle got=%0d exp=%0d", dn_at, FRAME - 1); end
    checks++; if (active !== 1'b0 || serial !== 1'b1) begin failures++; $display("FAIL single_idle got=%b/%b exp=0/1", active, serial); end
  endtask

  task automatic test_back_to_back();
    int idle;
    int b;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dv = 1'b1;
      tx_byte = 8'(i);
      tick();
    end
    dv = 1'b0;
    idle = 0;
    b = 8 * FRAME + 200;
    while (done_q.size() < 8 && b > 0) begin
      if (active !== 1'b1) idle++;
      tick();
      b--;
    end
    checks++; if (done_q.size() != 8) begin failures++; $display("FAIL b2b_done_count got=%0d exp=8", done_q.size()); end
    checks++; if (idle != 0)          begin failures++; $display("FAIL b2b_idle_clocks got=%0d exp=0", idle); end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (i >= done_q.size() || done_q[i] - done_q[i-1] != FRAME) begin
        failures++; $display("FAIL b2b_done_spacing%0d got=%0d exp=%0d", i, (i < done_q.size()) ? done_q[i] - done_q[i-1] : -1, FRAME);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== 8'(i)) begin failures++; $display("FAIL b2b_byte%0d got=%0h exp=%0h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, i); end
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
    repeat (2) tick();
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL b2b_end_active got=%b exp=0", active); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      dv = 1'b1;
      tx_byte = 8'hA0 + 8'(i);
      tick();
    end
    dv = 1'b0;
    checks++; if (count !== 4'd8)    begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
    checks++; if (ready !== 1'b0)    begin failures++; $display("FAIL ovf_ready got=%b exp=0", ready); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    wait_dones(9, 9 * FRAME + 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout got=%0d exp=9", done_q.size()); end
    repeat (2) tick();
    checks++; if (rx_q.size() != 9) begin failures++; $display("FAIL ovf_frames got=%0d exp=9", rx_q.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL ovf_byte%0d got=%0h exp=%0h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'hA0 + 8'(i)); end
    end
    checks++; if (count !== 4'd0 || active !== 1'b0 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_end got=%0d/%b/%b exp=0/0/1", count, active, overflow); end
  endtask

  task automatic test_full_pop_push();
    bit ok;
    int b;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      dv = 1'b1;
      tx_byte = 8'hB0 + 8'(i);
      tick();
    end
    dv = 1'b0;
    checks++; if (count !== 4'd8 || ready !== 1'b0) begin failures++; $display("FAIL fpp_full got=%0d/%b exp=8/0", count, ready); end
    b = FRAME + 100;
    while (done !== 1'b1 && b > 0) begin
      tick();
      b--;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL fpp_done_timeout got=%b exp=1", done); end
    dv = 1'b1;
    tx_byte = 8'hEE;
    tick();
    dv = 1'b0;
    checks++; if (count !== 4'd7)    begin failures++; $display("FAIL fpp_count got=%0d exp=7", count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fpp_overflow got=%b exp=1", overflow); end
    checks++; if (ready !== 1'b1)    begin failures++; $display("FAIL fpp_ready got=%b exp=1", ready); end
    checks++; if (serial !== 1'b0 || active !== 1'b1) begin failures++; $display("FAIL fpp_next_start got=%b/%b exp=0/1", serial, active); end
    wait_dones(9, 8 * FRAME + 200, ok);
    repeat (2) tick();
    checks++; if (rx_q.size() != 9) begin failures++; $display("FAIL fpp_frames got=%0d exp=9", rx_q.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== 8'hB0 + 8'(i)) begin failures++; $display("FAIL fpp_byte%0d got=%0h exp=%0h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'hB0 + 8'(i)); end
    end
  endtask

  task automatic test_loopback();
    bit ok;
    do_reset();
    dv = 1'b1;
    tx_byte = 8'h56;
    tick();
    dv = 1'b0;
    wait_dones(1, FRAME + 100, ok);
    tick();
    checks++; if (!ok || rx_q.size() != 1) begin failures++; $display("FAIL loop_dv got=%0d exp=1", rx_q.size()); end
    checks++; if (rx_q.size() < 1 || rx_q[0] !== 8'h56) begin failures++; $display("FAIL loop_byte got=%0h exp=56", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dv = 1'b1;
      tx_byte = 8'hC0 + 8'(i);
      tick();
    end
    dv = 1'b0;
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL rmf_queued got=%0d exp=3", count); end
    repeat (3 * CPB) tick();
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL rmf_in_frame got=%b exp=1", active); end
    rst_l = 1'b0;
    tick();
    checks++; if (serial !== 1'b1) begin failures++; $display("FAIL rmf_serial got=%b exp=1", serial); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL rmf_active got=%b exp=0", active); end
    checks++; if (count !== 4'd0)  begin failures++; $display("FAIL rmf_count got=%0d exp=0", count); end
    rst_l = 1'b1;
    done_q.delete();
    bad = 0;
    repeat (FRAME + 300) begin
      tick();
      if (active !== 1'b0 || serial !== 1'b1) bad++;
    end
    checks++; if (bad != 0)          begin failures++; $display("FAIL rmf_no_frame got=%0d exp=0", bad); end
    checks++; if (done_q.size() != 0) begin failures++; $display("FAIL rmf_no_done got=%0d exp=0", done_q.size()); end
  endtask

  initial begin
    rst_l   = 1'b0;
    dv      = 1'b0;
    tx_byte = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop_push();
    test_loopback();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
